// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: owns the 128-bit state, sequences the
// initial AddRoundKey and NR rounds through an external round-function datapath.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         key_req,
  output logic [3:0]   key_idx,
  input  logic         key_valid,
  input  logic [127:0] round_key,
  output logic [127:0] rf_state,
  output logic         rf_last,
  input  logic [127:0] rf_result,
  output logic         busy
);

  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [1:0] {IDLE, ARK0, ROUND, DONE} fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [127:0] st, st_nxt;
  logic [3:0]   round, round_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm   <= IDLE;
      st    <= '0;
      round <= '0;
    end else begin
      fsm   <= fsm_nxt;
      st    <= st_nxt;
      round <= round_nxt;
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    st_nxt    = st;
    round_nxt = round;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_req   = 1'b0;
    key_idx   = '0;
    rf_last   = 1'b0;
    case (fsm)
      IDLE: begin
        // gated by rst so the block never looks ready while held in reset
        in_ready = !rst;
        if (in_valid && in_ready) begin
          st_nxt    = in_block;
          round_nxt = '0;
          fsm_nxt   = ARK0;
        end
      end
      ARK0: begin
        key_req = 1'b1;
        if (key_valid) begin
          st_nxt    = st ^ round_key;
          round_nxt = 4'd1;
          fsm_nxt   = ROUND;
        end
      end
      ROUND: begin
        key_req = 1'b1;
        key_idx = round;
        rf_last = (round == LAST);
        if (key_valid) begin
          st_nxt = rf_result ^ round_key;
          if (round == LAST) fsm_nxt = DONE;
          else               round_nxt = round + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  assign rf_state  = st;
  assign out_block = st;
  assign busy      = (fsm != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with an AES-128 round-function and key-schedule
// model attached; expected ciphertexts go through a scoreboard queue.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         key_req;
  logic [3:0]   key_idx;
  logic         key_valid;
  logic [127:0] round_key;
  logic [127:0] rf_state;
  logic         rf_last;
  logic [127:0] rf_result;
  logic         busy;

  logic [127:0] cipher_key;
  logic [127:0] sbq[$];
  int           n_assert = 0;
  int           n_fail   = 0;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .key_req   (key_req),
    .key_idx   (key_idx),
    .key_valid (key_valid),
    .round_key (round_key),
    .rf_state  (rf_state),
    .rf_last   (rf_last),
    .rf_result (rf_result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // multiplicative inverse as a^254, then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gm(r, r);
      if (e[i]) r = gm(r, a);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] rf_model(input logic [127:0] s, input logic last);
    logic [7:0]   a[16];
    logic [7:0]   b[16];
    logic [7:0]   m[16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = gm(b[4*c], 8'd2) ^ gm(b[4*c+1], 8'd3) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ gm(b[4*c+1], 8'd2) ^ gm(b[4*c+2], 8'd3) ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ gm(b[4*c+2], 8'd2) ^ gm(b[4*c+3], 8'd3);
      m[4*c+3] = gm(b[4*c], 8'd3) ^ b[4*c+1] ^ b[4*c+2] ^ gm(b[4*c+3], 8'd2);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = last ? b[i] : m[i];
    return o;
  endfunction

  function automatic logic [127:0] rkey(input logic [127:0] key, input logic [3:0] idx);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          k;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    if (idx > 4'd10) return '0;
    k = int'(idx);
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ rkey(key, 4'd0);
    for (int r = 1; r <= 10; r++) s = rf_model(s, r == 10) ^ rkey(key, 4'(r));
    return s;
  endfunction

  assign round_key = rkey(cipher_key, key_idx);
  assign rf_result = rf_model(rf_state, rf_last);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block, drive key_valid per stall plan, check the key sequence and latency.
  task automatic run_block(input logic [127:0] blk, input int st0, input int st5,
                           input int exp_edges, input bit pulse_mid);
    int           edges = 0;
    int           exp_idx = 0;
    int           s0 = st0;
    int           s5 = st5;
    bit           stalled = 1'b0;
    logic [127:0] prev_rf = '0;
    sbq.push_back(encrypt(blk, cipher_key));
    @(negedge clk);
    chk("in_ready_idle", 128'(in_ready), 128'd1);
    in_block = blk;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    while (edges < 40 && !out_valid) begin
      chk("busy_run", 128'(busy), 128'd1);
      chk("in_ready_busy", 128'(in_ready), 128'd0);
      chk("key_req", 128'(key_req), 128'd1);
      chk("key_idx_seq", 128'(key_idx), 128'(exp_idx));
      chk("rf_last", 128'(rf_last), 128'(exp_idx == 10));
      if (stalled) chk("rf_state_stall", rf_state, prev_rf);
      prev_rf = rf_state;
      if (key_idx == 4'd0 && s0 > 0) begin
        key_valid = 1'b0;
        s0--;
      end else if (key_idx == 4'd5 && s5 > 0) begin
        key_valid = 1'b0;
        s5--;
      end else begin
        key_valid = 1'b1;
      end
      stalled = !key_valid;
      if (key_valid) exp_idx++;
      in_valid = pulse_mid && edges == 4;
      if (in_valid) in_block = ~blk;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      edges++;
    end
    key_valid = 1'b1;
    chk("latency", 128'(edges), 128'(exp_edges));
    chk("rf_last_done", 128'(rf_last), 128'd0);
    chk("key_req_done", 128'(key_req), 128'd0);
  endtask

  // Hold off out_ready for bp cycles, then pop and compare against the scoreboard.
  task automatic take_out(input int bp, input bit in_with_ready);
    logic [127:0] first = out_block;
    for (int k = 0; k < bp; k++) begin
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_block", out_block, first);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    chk("out_valid", 128'(out_valid), 128'd1);
    chk("sb_nonempty", 128'(sbq.size() != 0), 128'd1);
    if (sbq.size() != 0) chk("ciphertext", out_block, sbq.pop_front());
    out_ready = 1'b1;
    if (in_with_ready) begin
      in_valid = 1'b1;
      in_block = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid_drop", 128'(out_valid), 128'd0);
    chk("busy_idle", 128'(busy), 128'd0);
    chk("in_ready_after", 128'(in_ready), 128'd1);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_block   = '0;
    out_ready  = 1'b0;
    key_valid  = 1'b1;
    cipher_key = FIPS_KEY;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_key_req", 128'(key_req), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_rf_state", rf_state, '0);
    chk("rst_rf_last", 128'(rf_last), 128'd0);
    rst = 1'b0;

    run_block(FIPS_PT, 0, 0, 11, 1'b0);
    chk("fips_c1", out_block, FIPS_CT);
    take_out(0, 1'b0);

    run_block(FIPS_PT, 3, 2, 16, 1'b0);
    chk("fips_c1_stall", out_block, FIPS_CT);
    take_out(5, 1'b1);

    run_block(FIPS_PT, 0, 0, 11, 1'b1);
    take_out(0, 1'b0);

    // reset in round 4, between edges
    @(negedge clk);
    in_block = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 20 && key_idx != 4'd4) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_round4", 128'(key_idx), 128'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_key_req", 128'(key_req), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_state", rf_state, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 128'(in_ready), 128'd1);

    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    run_block({$urandom, $urandom, $urandom, $urandom}, 1, 0, 12, 1'b0);
    take_out(2, 1'b0);
    chk("sb_drained", 128'(sbq.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
